// File: rtl/psola_frame_scheduler_if.sv
// Output sample stream between the frame scheduler and the audio path.
// Valid/ready handshake; the scheduler side is the master.
interface psola_frame_scheduler_if;
    logic [31:0] sample_out;
    logic        sample_valid_out;
    logic        sample_ready_in;

    modport master (
        output sample_out,
        output sample_valid_out,
        input  sample_ready_in
    );

    modport slave (
        input  sample_out,
        input  sample_valid_out,
        output sample_ready_in
    );
endinterface

// File: rtl/psola_frame_scheduler.sv
// Per-frame sequencer for PSOLA resynthesis: pitch check, start,
// completion wait with watchdog, and streaming drain of the output buffer.
module psola_frame_scheduler #(
    parameter int WINDOW_SIZE    = 2048,
    parameter int MIN_PERIOD     = 16,
    parameter int TIMEOUT_CYCLES = 1 << 20,
    localparam int AW            = $clog2(2 * WINDOW_SIZE)
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    frame_ready_in,
    input  logic                    pitch_valid_in,
    input  logic [11:0]             pitch_in,
    output logic                    psola_start_out,
    output logic [11:0]             psola_period_out,
    input  logic                    psola_done_in,
    input  logic [11:0]             psola_len_in,
    output logic [AW-1:0]           rd_addr_out,
    input  logic [31:0]             rd_data_in,
    psola_frame_scheduler_if.master smp,
    output logic                    busy_out,
    output logic [15:0]             overrun_count_out,
    output logic [15:0]             skip_count_out,
    output logic                    timeout_out
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0] MIN_P = 12'(MIN_PERIOD);
    localparam logic [11:0] MAX_P = 12'(WINDOW_SIZE / 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]     state_q;
    logic [2:0]     state_d;
    logic           first_q;
    logic [WDW-1:0] wd_q;
    logic [11:0]    drain_len_q;
    logic           valid_q;

    logic pitch_ok;
    logic take_pitch;
    logic done_ok;
    logic wd_hit;
    logic hs;
    logic last_addr;
    logic ovr_hit;

    assign pitch_ok   = (pitch_in >= MIN_P) && (pitch_in < MAX_P);
    assign take_pitch = pitch_valid_in &&
                        ((state_q == S_IDLE && frame_ready_in) ||
                         state_q == S_WAIT);
    assign done_ok    = (state_q == S_RUN) && psola_done_in && !first_q;
    assign wd_hit     = (state_q == S_RUN) && !done_ok && (wd_q == WD_LAST);
    assign hs         = valid_q && smp.sample_ready_in;
    assign last_addr  = rd_addr_out == AW'(drain_len_q - 12'd1);
    assign ovr_hit    = frame_ready_in && (state_q != S_IDLE);

    assign smp.sample_valid_out = valid_q;
    assign smp.sample_out       = valid_q ? rd_data_in : 32'd0;

    // Next-state selection for the frame sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame_ready_in) begin
                    if (pitch_valid_in)
                        state_d = pitch_ok ? S_START : S_IDLE;
                    else
                        state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pitch_valid_in)
                    state_d = pitch_ok ? S_START : S_IDLE;
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (done_ok)
                    state_d = (psola_len_in == 12'd0) ? S_IDLE : S_DRAIN;
                else if (wd_hit)
                    state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (hs && last_addr)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, registered busy/start/valid flags and the watchdog
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= S_IDLE;
            busy_out        <= 1'b0;
            psola_start_out <= 1'b0;
            valid_q         <= 1'b0;
            first_q         <= 1'b0;
            wd_q            <= '0;
            timeout_out     <= 1'b0;
        end else begin
            state_q         <= state_d;
            busy_out        <= (state_d != S_IDLE);
            psola_start_out <= (state_d == S_START);
            valid_q         <= (state_d == S_DRAIN);
            first_q         <= (state_q == S_START);
            if (state_q == S_START)
                wd_q <= '0;
            else if (state_q == S_RUN)
                wd_q <= wd_q + WDW'(1);
            if (wd_hit)
                timeout_out <= 1'b1;
        end
    end

    // Period latch, drain length and read address
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            psola_period_out <= '0;
            drain_len_q      <= '0;
            rd_addr_out      <= '0;
        end else begin
            if (take_pitch && pitch_ok)
                psola_period_out <= pitch_in;
            if (done_ok) begin
                drain_len_q <= psola_len_in;
                rd_addr_out <= '0;
            end else if (state_q == S_DRAIN && hs) begin
                rd_addr_out <= rd_addr_out + AW'(1);
            end
        end
    end

    // Saturating overrun and skip counters
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            overrun_count_out <= '0;
            skip_count_out    <= '0;
        end else begin
            if (ovr_hit && overrun_count_out != 16'hFFFF)
                overrun_count_out <= overrun_count_out + 16'd1;
            if (take_pitch && !pitch_ok && skip_count_out != 16'hFFFF)
                skip_count_out <= skip_count_out + 16'd1;
        end
    end

endmodule

// File: tb/tb_psola_frame_scheduler.sv
// Randomised bench for psola_frame_scheduler with a PSOLA/buffer model
// and a frame-level reference of starts, samples and counters.
module tb_psola_frame_scheduler;

    localparam int WS   = 2048;
    localparam int MINP = 16;
    localparam int TO   = 64;
    localparam int AW   = 12;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic          rst_n_in;
    logic          frame_ready_in;
    logic          pitch_valid_in;
    logic [11:0]   pitch_in;
    logic          psola_start_out;
    logic [11:0]   psola_period_out;
    logic          psola_done_in = 1'b0;
    logic [11:0]   psola_len_in = 12'd0;
    logic [AW-1:0] rd_addr_out;
    logic [31:0]   rd_data_in;
    logic          busy_out;
    logic [15:0]   overrun_count_out;
    logic [15:0]   skip_count_out;
    logic          timeout_out;

    psola_frame_scheduler_if smp ();

    psola_frame_scheduler #(
        .WINDOW_SIZE(WS),
        .MIN_PERIOD(MINP),
        .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .frame_ready_in(frame_ready_in),
        .pitch_valid_in(pitch_valid_in),
        .pitch_in(pitch_in),
        .psola_start_out(psola_start_out),
        .psola_period_out(psola_period_out),
        .psola_done_in(psola_done_in),
        .psola_len_in(psola_len_in),
        .rd_addr_out(rd_addr_out),
        .rd_data_in(rd_data_in),
        .smp(smp),
        .busy_out(busy_out),
        .overrun_count_out(overrun_count_out),
        .skip_count_out(skip_count_out),
        .timeout_out(timeout_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Output buffer: a bijective word per address, salted per frame
    logic [31:0] salt = 32'h0;
    function automatic logic [31:0] word_at(input logic [31:0] s,
                                            input int a);
        return s ^ (32'(a) * 32'h9E3779B1);
    endfunction
    always_comb rd_data_in = word_at(salt, int'(rd_addr_out));

    // PSOLA engine model: done is cleared one cycle late after a start
    int          cfg_len = 0;
    int          cfg_delay = 10;
    bit          cfg_never = 1'b0;
    int          age = 0;
    bit          running = 1'b0;
    int          starts = 0;
    logic [11:0] seen_period = 12'd0;
    int          start_cyc = 0;
    always @(negedge clk_in) begin
        if (psola_start_out) begin
            starts      <= starts + 1;
            seen_period <= psola_period_out;
            start_cyc   <= cyc;
            age         <= 0;
            running     <= 1'b1;
        end else if (running) begin
            age <= age + 1;
            if (age + 1 == 2)
                psola_done_in <= 1'b0;
            if (!cfg_never && age + 1 == cfg_delay) begin
                psola_done_in <= 1'b1;
                psola_len_in  <= 12'(cfg_len);
            end
        end
    end

    // Downstream sink: collect accepted samples, check stall stability
    typedef struct {
        int          a;
        logic [31:0] d;
        int          c;
    } beat_t;
    beat_t       got[$];
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [31:0] ps = 32'd0;
    always @(negedge clk_in) begin
        if (rst_n_in && smp.sample_valid_out && smp.sample_ready_in)
            got.push_back('{int'(rd_addr_out), smp.sample_out, cyc});
        if (rst_n_in && pv && !pr)
            check("stall_hold",
                  {31'd0, smp.sample_valid_out, smp.sample_out},
                  {32'd1, ps});
        pv <= rst_n_in && smp.sample_valid_out;
        pr <= smp.sample_ready_in;
        ps <= smp.sample_out;
    end

    // Ready driver: 0 = tied high, 1 = 1,0,0,1 pattern, 2 = random
    int rmode = 0;
    int ph = 0;
    initial begin
        smp.sample_ready_in = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            ph++;
            case (rmode)
                1: smp.sample_ready_in = (ph % 4 == 0) || (ph % 4 == 3);
                2: smp.sample_ready_in = 1'($urandom);
                default: smp.sample_ready_in = 1'b1;
            endcase
        end
    end

    int exp_skip = 0;
    int exp_ovr  = 0;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl"}, {60'd0, psola_start_out, smp.sample_valid_out,
                               busy_out, timeout_out}, 64'd0);
        check({tag, "_data"}, {8'd0, psola_period_out, rd_addr_out,
                               smp.sample_out}, 64'd0);
        check({tag, "_cnt"}, {32'd0, overrun_count_out, skip_count_out},
              64'd0);
    endtask

    task automatic run_frame(input int p, input bit same, input int gap,
                             input int len, input int delay, input int mode,
                             input int ovr);
        int  s0;
        int  n;
        int  cend;
        bit  ok;
        cfg_len   = len;
        cfg_delay = delay;
        cfg_never = 1'b0;
        rmode     = mode;
        salt      = $urandom;
        got.delete();
        s0 = starts;
        ok = (p >= MINP) && (p < WS / 2);
        if (same) begin
            frame_ready_in = 1'b1;
            pitch_valid_in = 1'b1;
            pitch_in       = 12'(p);
            tick();
            frame_ready_in = 1'b0;
            pitch_valid_in = 1'b0;
        end else begin
            frame_ready_in = 1'b1;
            tick();
            frame_ready_in = 1'b0;
            repeat (gap) tick();
            pitch_valid_in = 1'b1;
            pitch_in       = 12'(p);
            tick();
            pitch_valid_in = 1'b0;
        end
        if (ovr > 0) begin
            repeat (3) tick();
            for (int i = 0; i < ovr; i++) begin
                frame_ready_in = 1'b1;
                tick();
                frame_ready_in = 1'b0;
                tick();
            end
        end
        n = 0;
        while (busy_out && n < 20000) begin
            tick();
            n++;
        end
        cend = cyc;
        check("frame_end", 64'(n < 20000), 64'd1);
        tick();
        if (ok) begin
            exp_ovr += ovr;
            check("start_cnt", 64'(starts - s0), 64'd1);
            check("period", 64'(seen_period), 64'(p));
            check("n_samples", 64'(got.size()), 64'(len));
            for (int i = 0; i < got.size() && i < len; i++) begin
                check("s_addr", 64'(got[i].a), 64'(i));
                check("s_data", 64'(got[i].d), 64'(word_at(salt, i)));
            end
            if (len > 0 && got.size() > 0) begin
                check("busy_drop", 64'(cend - got[got.size()-1].c), 64'd1);
                if (mode == 0)
                    check("one_per_cyc",
                          64'(got[got.size()-1].c - got[0].c),
                          64'(len - 1));
            end
        end else begin
            exp_skip++;
            check("no_start", 64'(starts - s0), 64'd0);
            check("no_samples", 64'(got.size()), 64'd0);
        end
        check("skip_cnt", 64'(skip_count_out), 64'(exp_skip));
        check("ovr_cnt", 64'(overrun_count_out), 64'(exp_ovr));
        check("idle", 64'(busy_out), 64'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int s0;
        int p;
        rst_n_in       = 1'b0;
        frame_ready_in = 1'b0;
        pitch_valid_in = 1'b0;
        pitch_in       = 12'd0;
        repeat (3) tick();
        check_reset_state("reset");
        rst_n_in = 1'b1;
        repeat (2) tick();

        run_frame(100, 1'b0, 2, 300, 50, 0, 0);
        run_frame(8, 1'b0, 1, 5, 10, 0, 0);
        run_frame(1024, 1'b0, 1, 5, 10, 0, 0);
        run_frame(10, 1'b0, 1, 10, 12, 1, 0);
        run_frame(MINP, 1'b1, 0, 10, 12, 1, 0);
        run_frame(1023, 1'b0, 0, 0, 6, 0, 0);
        run_frame(200, 1'b0, 1, 20, 40, 0, 3);

        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1)
                p = $urandom_range(MINP, WS / 2 - 1);
            else if ($urandom_range(0, 1) == 1)
                p = $urandom_range(0, MINP - 1);
            else
                p = $urandom_range(WS / 2, 4095);
            run_frame(p, 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 40), $urandom_range(3, 30),
                      $urandom_range(0, 2), 0);
        end

        cfg_never = 1'b1;
        rmode     = 0;
        got.delete();
        s0 = starts;
        frame_ready_in = 1'b1;
        pitch_valid_in = 1'b1;
        pitch_in       = 12'd200;
        tick();
        frame_ready_in = 1'b0;
        pitch_valid_in = 1'b0;
        n = 0;
        while (!timeout_out && n < 500) begin
            tick();
            n++;
        end
        check("wd_seen", 64'(n < 500), 64'd1);
        check("wd_start", 64'(starts - s0), 64'd1);
        check("wd_latency", 64'(cyc - start_cyc), 64'd65);
        check("wd_idle", 64'(busy_out), 64'd0);
        tick();
        check("wd_no_drain", 64'(got.size()), 64'd0);
        run_frame(150, 1'b0, 1, 12, 9, 0, 0);
        check("wd_sticky", 64'(timeout_out), 64'd1);

        cfg_len   = 300;
        cfg_delay = 10;
        cfg_never = 1'b0;
        rmode     = 0;
        got.delete();
        frame_ready_in = 1'b1;
        pitch_valid_in = 1'b1;
        pitch_in       = 12'd100;
        tick();
        frame_ready_in = 1'b0;
        pitch_valid_in = 1'b0;
        n = 0;
        while (got.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        check("rst_reach_s5", 64'(n < 200), 64'd1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_reset_state("rst_mid");
        repeat (3) tick();
        rst_n_in = 1'b1;
        exp_skip = 0;
        exp_ovr  = 0;
        got.delete();
        s0 = starts;
        repeat (30) tick();
        check("rst_no_samples", 64'(got.size()), 64'd0);
        check("rst_no_start", 64'(starts - s0), 64'd0);
        check("rst_idle", 64'(busy_out), 64'd0);
        run_frame(64, 1'b0, 3, 25, 20, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psola_frame_scheduler.md
Name: psola_frame_scheduler

Overview:
- Sequences the PSOLA resynthesis datapath for each analysis frame.
- Waits for a filled analysis window and a pitch estimate, validates the period, and issues a one-cycle start with the period latched.
- Waits for the PSOLA done, then streams the resynthesised samples to the audio output path using a valid/ready handshake.
- Drops frames it cannot service, counts overruns and aborts on a watchdog timeout.

Parameters:
WINDOW_SIZE, 2048, analysis window length in samples; PSOLA output buffer holds 2*WINDOW_SIZE.
MIN_PERIOD, 16, smallest period accepted for resynthesis.
TIMEOUT_CYCLES, 2^20, maximum cycles to wait for psola_done after a start.

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
frame_ready_in  input  1  one-cycle pulse: analysis window buffer is full and stable
pitch_valid_in  input  1  one-cycle pulse: pitch_in holds a new estimate
pitch_in  input  12  detected period in samples
psola_start_out  output  1  one-cycle start pulse (drives new_signal)
psola_period_out  output  12  latched period, held stable from start until the next start
psola_done_in  input  1  PSOLA completion, sampled as a level
psola_len_in  input  12  PSOLA output_window_len, valid when psola_done_in=1
rd_addr_out  output  log2(2*WINDOW_SIZE)  read index into the PSOLA output array
rd_data_in  input  32  signed sample at rd_addr_out (combinational mux outside this block)
sample_out  output  32  output sample
sample_valid_out  output  1  sample_out is valid
sample_ready_in  input  1  downstream accepts the sample
busy_out  output  1  high in every state except IDLE
overrun_count_out  output  16  frames dropped because the block was busy (saturating)
skip_count_out  output  16  frames skipped because the period was invalid (saturating)
timeout_out  output  1  sticky flag, set when the watchdog expires

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0.
  - Period latch 0.
  - Counters 0.
  - timeout_out=0.
- States: IDLE, WAIT_PITCH, START, RUN, DRAIN.
- IDLE:
  - frame_ready_in -> WAIT_PITCH.
  - If pitch_valid_in is asserted in the same cycle, pitch_in is captured and the next state is START directly, provided the period is valid.
- WAIT_PITCH:
  - On pitch_valid_in, the period is valid when MIN_PERIOD <= pitch_in < WINDOW_SIZE/2.
  - Valid period: latch it into psola_period_out -> START.
  - Invalid period: skip_count_out+1 -> IDLE.
- START:
  - psola_start_out=1 for exactly one cycle.
  - Watchdog counter cleared.
  - -> RUN.
- RUN:
  - Wait for psola_done_in; psola_done_in is ignored in the first cycle after START, because PSOLA clears done one cycle late.
  - On done: latch psola_len_in as drain_len, set rd_addr_out=0.
  - drain_len=0 -> IDLE; otherwise -> DRAIN.
  - The watchdog increments each RUN cycle. On reaching TIMEOUT_CYCLES: set timeout_out -> IDLE with no drain.
- DRAIN:
  - sample_out = rd_data_in; sample_valid_out=1.
  - On sample_valid_out && sample_ready_in: rd_addr_out+1.
  - When the accepted address equals drain_len-1: sample_valid_out drops next cycle -> IDLE.
  - sample_out and sample_valid_out are held stable while sample_ready_in=0 (AXI-stream rule; valid never depends on ready).
- frame_ready_in in any state other than IDLE: overrun_count_out+1 (saturating at 0xFFFF); the frame is not queued.
- pitch_valid_in outside IDLE and WAIT_PITCH is ignored.
- Simultaneous frame_ready_in and final drain handshake: counted as an overrun; the state still returns to IDLE.
- Reset mid-operation: immediate return to the reset values. No start pulse is emitted after reset until a new frame_ready_in arrives.
- busy_out is registered and equals (state != IDLE).

Test Plan:
- Basic frame:
  - Stimulus: frame_ready, then pitch_valid with pitch=100 three cycles later. PSOLA model raises done 50 cycles after start with len=300, ready tied to 1.
  - Required response: one start pulse with period=100; exactly 300 samples at addresses 0..299, one per cycle; busy drops after the last sample.
- Invalid period:
  - Stimulus: pitch=8, then pitch=1024, each in a separate frame (WINDOW_SIZE=2048).
  - Required response: no start pulse; skip_count=2; state returns to IDLE.
- Backpressure:
  - Stimulus: len=10, ready toggling 1,0,0,1 repeatedly.
  - Required response: 10 unique samples in order; no duplicates; sample_out stable during every stalled cycle.
- Overrun:
  - Stimulus: frame_ready pulsed 3 times during RUN.
  - Required response: overrun_count=3; the current frame completes normally.
- Watchdog:
  - Stimulus: done is never asserted (TIMEOUT_CYCLES=64 in the bench).
  - Required response: timeout_out=1 at RUN cycle 64; return to IDLE; the next frame is processed normally.
- Reset mid-drain:
  - Stimulus: rst_n_in low at sample 5 of 300.
  - Required response: outputs 0 asynchronously; no valid sample after release until a new frame completes.
